// File: rtl/sad_min_tracker_ex3.sv
// EX3-stage SAD running-minimum tracker: keeps the smallest candidate SAD of a motion-search
// frame with its window coordinates, counts candidates and rows, and pulses Done at end of frame.
module sad_min_tracker_ex3 #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    input  logic              sad_EX3,
    input  logic [DATA_W-1:0] t1_sad_value_EX3,
    input  logic [DATA_W-1:0] s6_x_value_EX3,
    input  logic [DATA_W-1:0] s7_y_value_EX3,
    input  logic [1:0]        check_wcol_out_EX3,
    output logic [DATA_W-1:0] MinSAD,
    output logic [DATA_W-1:0] BestX,
    output logic [DATA_W-1:0] BestY,
    output logic [CNT_W-1:0]  CandCount,
    output logic [CNT_W-1:0]  RowCount,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_best_x;
    logic [DATA_W-1:0] r_best_y;
    logic [CNT_W-1:0]  r_cand;
    logic [CNT_W-1:0]  r_row;

    logic w_init;
    logic w_accept;
    logic w_better;
    logic w_last_col;
    logic w_last_win;

    // Start wins over a same-cycle candidate; code 11 falls through as interior
    assign w_init     = Start & ~Stall;
    assign w_accept   = (r_state == StScan) & sad_EX3 & ~Stall & ~Start;
    assign w_better   = t1_sad_value_EX3 < r_min;
    assign w_last_col = check_wcol_out_EX3 == 2'b01;
    assign w_last_win = check_wcol_out_EX3 == 2'b10;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_init) w_state_next = StScan;
            end
            StScan: begin
                if (w_accept && w_last_win) w_state_next = StDone;
            end
            // Done never lingers, even under Stall
            StDone: begin
                w_state_next = w_init ? StScan : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        unique case (r_state)
            StScan:  Busy = 1'b1;
            StDone:  Done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_min    <= '1;
            r_best_x <= '0;
            r_best_y <= '0;
            r_cand   <= '0;
            r_row    <= '0;
        end else if (w_init) begin
            r_min    <= '1;
            r_best_x <= '0;
            r_best_y <= '0;
            r_cand   <= '0;
            r_row    <= '0;
        end else if (w_accept) begin
            if (r_cand != {CNT_W{1'b1}}) r_cand <= r_cand + CNT_W'(1);
            if (w_better) begin
                r_min    <= t1_sad_value_EX3;
                r_best_x <= s6_x_value_EX3;
                r_best_y <= s7_y_value_EX3;
            end
            if ((w_last_col || w_last_win) && (r_row != {CNT_W{1'b1}})) begin
                r_row <= r_row + CNT_W'(1);
            end
        end
    end

    assign MinSAD    = r_min;
    assign BestX     = r_best_x;
    assign BestY     = r_best_y;
    assign CandCount = r_cand;
    assign RowCount  = r_row;

endmodule

// File: tb/tb_sad_min_tracker_ex3.sv
// Directed-vector bench for sad_min_tracker_ex3; a second narrow-counter instance checks saturation.
module tb_sad_min_tracker_ex3;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Stall;
    logic        sad_EX3;
    logic [31:0] t1_sad_value_EX3;
    logic [31:0] s6_x_value_EX3;
    logic [31:0] s7_y_value_EX3;
    logic [1:0]  check_wcol_out_EX3;
    logic [31:0] MinSAD;
    logic [31:0] BestX;
    logic [31:0] BestY;
    logic [15:0] CandCount;
    logic [15:0] RowCount;
    logic        Busy;
    logic        Done;

    logic [31:0] s_min;
    logic [31:0] s_bx;
    logic [31:0] s_by;
    logic [3:0]  s_cand;
    logic [3:0]  s_row;
    logic        s_busy;
    logic        s_done;

    int n_vec;
    int n_err;

    sad_min_tracker_ex3 #(.DATA_W(32), .CNT_W(16)) u_dut (
        .Clk                (Clk),
        .Reset              (Reset),
        .Start              (Start),
        .Stall              (Stall),
        .sad_EX3            (sad_EX3),
        .t1_sad_value_EX3   (t1_sad_value_EX3),
        .s6_x_value_EX3     (s6_x_value_EX3),
        .s7_y_value_EX3     (s7_y_value_EX3),
        .check_wcol_out_EX3 (check_wcol_out_EX3),
        .MinSAD             (MinSAD),
        .BestX              (BestX),
        .BestY              (BestY),
        .CandCount          (CandCount),
        .RowCount           (RowCount),
        .Busy               (Busy),
        .Done               (Done)
    );

    sad_min_tracker_ex3 #(.DATA_W(32), .CNT_W(4)) u_dut_small (
        .Clk                (Clk),
        .Reset              (Reset),
        .Start              (Start),
        .Stall              (Stall),
        .sad_EX3            (sad_EX3),
        .t1_sad_value_EX3   (t1_sad_value_EX3),
        .s6_x_value_EX3     (s6_x_value_EX3),
        .s7_y_value_EX3     (s7_y_value_EX3),
        .check_wcol_out_EX3 (check_wcol_out_EX3),
        .MinSAD             (s_min),
        .BestX              (s_bx),
        .BestY              (s_by),
        .CandCount          (s_cand),
        .RowCount           (s_row),
        .Busy               (s_busy),
        .Done               (s_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic cand(input logic [31:0] sad, input logic [31:0] x, input logic [31:0] y,
                        input logic [1:0] code);
        sad_EX3            = 1'b1;
        t1_sad_value_EX3   = sad;
        s6_x_value_EX3     = x;
        s7_y_value_EX3     = y;
        check_wcol_out_EX3 = code;
    endtask

    task automatic start_frame();
        Start   = 1'b1;
        sad_EX3 = 1'b0;
        tick();
        Start = 1'b0;
    endtask

    // Basic-minimum frame: (SAD, x, y, code)
    logic [31:0] b_sad [5] = '{100, 40, 70, 40, 90};
    logic [31:0] b_x   [5] = '{0, 1, 2, 0, 1};
    logic [31:0] b_y   [5] = '{0, 0, 0, 1, 1};
    logic [1:0]  b_cd  [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10};

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset = 1'b1;
        Start = 1'b0;
        Stall = 1'b0;
        sad_EX3 = 1'b0;
        t1_sad_value_EX3 = '0;
        s6_x_value_EX3 = '0;
        s7_y_value_EX3 = '0;
        check_wcol_out_EX3 = 2'b00;
        #12 Reset = 1'b0;
        #1;
        chk("rst_min", MinSAD, 32'hFFFF_FFFF);
        chk("rst_bestx", BestX, 0);
        chk("rst_besty", BestY, 0);
        chk("rst_cand", {16'd0, CandCount}, 0);
        chk("rst_row", {16'd0, RowCount}, 0);
        chk("rst_busy", {31'd0, Busy}, 0);
        chk("rst_done", {31'd0, Done}, 0);

        // Candidates in IDLE are ignored
        cand(0, 5, 5, 2'b10);
        tick();
        tick();
        chk("idle_min", MinSAD, 32'hFFFF_FFFF);
        chk("idle_cand", {16'd0, CandCount}, 0);
        chk("idle_busy", {31'd0, Busy}, 0);
        chk("idle_done", {31'd0, Done}, 0);

        // Basic minimum with tie
        start_frame();
        chk("bas_busy", {31'd0, Busy}, 1);
        chk("bas_init_min", MinSAD, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            cand(b_sad[i], b_x[i], b_y[i], b_cd[i]);
            tick();
            if (i == 0) chk("bas_first_min", MinSAD, 100);
            if (i < 4) chk("bas_no_done", {31'd0, Done}, 0);
        end
        sad_EX3 = 1'b0;
        chk("bas_done", {31'd0, Done}, 1);
        chk("bas_busy_done", {31'd0, Busy}, 0);
        chk("bas_min", MinSAD, 40);
        chk("bas_bestx", BestX, 1);
        chk("bas_besty", BestY, 0);
        chk("bas_cand", {16'd0, CandCount}, 5);
        chk("bas_row", {16'd0, RowCount}, 2);
        tick();
        chk("bas_done_off", {31'd0, Done}, 0);
        chk("bas_idle_busy", {31'd0, Busy}, 0);
        chk("bas_hold_min", MinSAD, 40);
        chk("bas_hold_x", BestX, 1);

        // Stall freezing
        start_frame();
        cand(10, 3, 3, 2'b00);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_cand", {16'd0, CandCount}, 0);
            chk("stl_min", MinSAD, 32'hFFFF_FFFF);
        end
        Stall = 1'b0;
        tick();
        sad_EX3 = 1'b0;
        chk("stl_cand_rel", {16'd0, CandCount}, 1);
        chk("stl_min_rel", MinSAD, 10);

        // Start restarts and discards the same-cycle candidate
        start_frame();
        cand(5, 1, 1, 2'b00);
        tick();
        chk("rs_min5", MinSAD, 5);
        Start = 1'b1;
        cand(1, 2, 2, 2'b00);
        tick();
        Start = 1'b0;
        sad_EX3 = 1'b0;
        chk("rs_min", MinSAD, 32'hFFFF_FFFF);
        chk("rs_cand", {16'd0, CandCount}, 0);
        chk("rs_busy", {31'd0, Busy}, 1);
        tick();
        chk("rs_min_after", MinSAD, 32'hFFFF_FFFF);

        // Back-to-back frames: Start during DONE
        cand(7, 3, 4, 2'b10);
        tick();
        sad_EX3 = 1'b0;
        chk("b2b_done", {31'd0, Done}, 1);
        chk("b2b_min", MinSAD, 7);
        chk("b2b_row", {16'd0, RowCount}, 1);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("b2b_done_off", {31'd0, Done}, 0);
        chk("b2b_busy", {31'd0, Busy}, 1);
        chk("b2b_min_init", MinSAD, 32'hFFFF_FFFF);
        chk("b2b_cand", {16'd0, CandCount}, 0);
        chk("b2b_row_init", {16'd0, RowCount}, 0);

        // Stall cannot stretch Done
        cand(9, 6, 8, 2'b11);
        tick();
        chk("c11_row", {16'd0, RowCount}, 0);
        cand(12, 6, 9, 2'b10);
        tick();
        sad_EX3 = 1'b0;
        chk("sd_done", {31'd0, Done}, 1);
        chk("sd_bestx", BestX, 6);
        chk("sd_besty", BestY, 8);
        Stall = 1'b1;
        tick();
        chk("sd_done_off", {31'd0, Done}, 0);
        chk("sd_busy", {31'd0, Busy}, 0);
        chk("sd_min_hold", MinSAD, 9);
        Stall = 1'b0;

        // Counter saturation on the 4-bit instance
        start_frame();
        for (int i = 0; i < 17; i++) begin
            cand(32'd1000 + i, i, 0, 2'b00);
            tick();
            if (i == 14) chk("sat_cand15", {28'd0, s_cand}, 15);
        end
        sad_EX3 = 1'b0;
        chk("sat_cand", {28'd0, s_cand}, 15);
        chk("sat_wide_cand", {16'd0, CandCount}, 17);
        chk("sat_min", s_min, 1000);

        // Asynchronous reset mid-scan
        start_frame();
        cand(50, 1, 0, 2'b00);
        tick();
        cand(20, 2, 0, 2'b00);
        tick();
        cand(30, 3, 0, 2'b00);
        tick();
        sad_EX3 = 1'b0;
        chk("ar_min_pre", MinSAD, 20);
        chk("ar_cand_pre", {16'd0, CandCount}, 3);
        #2 Reset = 1'b1;
        #1;
        chk("ar_min", MinSAD, 32'hFFFF_FFFF);
        chk("ar_busy", {31'd0, Busy}, 0);
        chk("ar_cand", {16'd0, CandCount}, 0);
        chk("ar_bestx", BestX, 0);
        #2 Reset = 1'b0;
        tick();
        chk("ar_idle_busy", {31'd0, Busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sad_min_tracker_ex3.md
Name: sad_min_tracker_ex3

Overview:
- EX3-stage consumer of the custom SAD instruction fields registered by the EX2→EX3 pipeline register.
- Scans the stream of candidate SAD values issued during a motion-search frame and keeps the running minimum with its (x, y) window coordinates.
- Reports a one-cycle completion pulse at end of frame.
- Outputs feed the EX3→MEM/WB path so the winning coordinates can be written back to outx/outy registers.

Parameters:
- DATA_W, 32, width of SAD value and coordinate ports
- CNT_W, 16, width of candidate and row counters (saturating)

Ports:
- Clk  input  1  pipeline clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  begin new frame search (decoded in EX3 from the search-init instruction)
- Stall  input  1  pipeline stall; when 1, no state, counter or minimum update
- sad_EX3  input  1  candidate valid strobe from the EX2→EX3 register
- t1_sad_value_EX3  input  DATA_W  candidate SAD value, unsigned
- s6_x_value_EX3  input  DATA_W  candidate window x
- s7_y_value_EX3  input  DATA_W  candidate window y
- check_wcol_out_EX3  input  2  window position code: 00 interior, 01 last column of row, 10 last window of frame, 11 treated as 00
- MinSAD  output  DATA_W  running minimum SAD
- BestX  output  DATA_W  x of current minimum
- BestY  output  DATA_W  y of current minimum
- CandCount  output  CNT_W  candidates accepted this frame
- RowCount  output  CNT_W  rows completed this frame
- Busy  output  1  1 while in SCAN
- Done  output  1  one-cycle pulse on frame completion

Behaviour:
- Reset (asynchronous, immediate, any state including mid-scan):
  - State = IDLE.
  - MinSAD = all ones.
  - BestX, BestY, CandCount, RowCount = 0.
  - Busy = 0, Done = 0.
- States and transitions:
  - IDLE: sad_EX3 ignored. Start & !Stall → SCAN, with MinSAD = all ones and BestX/BestY/counters cleared on the same edge.
  - SCAN: Busy = 1. A candidate is accepted when sad_EX3 & !Stall & !Start.
  - On accept:
    - CandCount += 1, saturating at 2^CNT_W-1.
    - If t1_sad_value_EX3 < MinSAD (strict unsigned): MinSAD/BestX/BestY load the candidate values on that edge. Ties keep the earlier candidate.
    - If code = 01: RowCount += 1, saturating.
    - If code = 10: the candidate is still compared, then → DONE. RowCount += 1 (the final row closes).
  - Start in SCAN (with !Stall): restarts. Registers re-initialise as on IDLE→SCAN; any same-cycle candidate is discarded; state stays SCAN.
  - DONE: Done = 1 for exactly this cycle; Busy = 0; results held.
    - Next edge → IDLE, or → SCAN (re-initialised) if Start is asserted.
    - Stall does not extend the Done pulse; DONE always exits after one cycle.
- Stall = 1 freezes state, outputs and counters. Exception: Done still deasserts after its cycle.
- Outputs are registered.
- Latency: the accepting edge updates MinSAD/BestX/BestY/CandCount, visible the cycle after the candidate is presented. Done is asserted the cycle after the code-10 candidate is accepted.
- MinSAD/BestX/BestY hold their values in IDLE after DONE until the next Start or Reset, so WB can read them later.
- A frame with zero accepted candidates never reaches DONE. MinSAD stays all ones.
- Width rules: compare is full DATA_W unsigned. No truncation of coordinates.

Test Plan:
- Reset mid-scan:
  - Stimulus: Start, then 3 candidates (SAD 50, 20, 30); assert Reset asynchronously between edges.
  - Response: outputs go to reset values immediately (MinSAD=FFFFFFFF, Busy=0) without waiting for Clk.
- Basic minimum:
  - Stimulus: Start; candidates (SAD, x, y, code) = (100,0,0,00), (40,1,0,00), (70,2,0,01), (40,0,1,00), (90,1,1,10).
  - Response: Done pulse one cycle after the last candidate; MinSAD=40, BestX=1, BestY=0 (tie keeps first), CandCount=5, RowCount=2.
- Stall freezing:
  - Stimulus: Start; candidate SAD=10 presented with Stall=1 for 3 cycles, then Stall=0.
  - Response: CandCount stays 0 during stall, then 1; MinSAD=10 only after stall release.
- Start restarts:
  - Stimulus: Start; accept SAD=5; then Start together with sad_EX3 (SAD=1).
  - Response: MinSAD=FFFFFFFF, CandCount=0, Busy=1; SAD=1 candidate discarded.
- Idle and wrap behaviour:
  - Stimulus: sad_EX3 pulses in IDLE with SAD=0.
  - Response: no change (MinSAD=FFFFFFFF).
  - Stimulus: with CNT_W=4, feed 17 interior candidates.
  - Response: CandCount saturates at 15.
- Back-to-back frames:
  - Stimulus: Start asserted during the DONE cycle.
  - Response: state → SCAN next edge with registers re-initialised; Done pulse width exactly one cycle.
